chi_deser: RTL
==============

Name: chi_deser

Overview:
- Receive side of the serialized chi-square path in the fitter: rebuilds the three per-combination chi values (CHI1, CHI2, CHI3) from a one-word-per-cycle chi stream.
- Picks the best (minimum) chi of each triple and presents the full result through a registered valid/ready output slot.
- The selection index it produces uses the same 2-bit SEL coding the transmit-side chi mux consumes: 00=CHI1, 01=CHI2, 10=CHI3. This block never produces 11.

Parameters:
- PARAMETERBITS, 14, width of every chi word (unsigned).

Ports:
- CLOCK  in  1  single clock; all state updates on posedge CLOCK.
- RESET_N  in  1  asynchronous, active-low reset.
- CHI  in  PARAMETERBITS  incoming serialized chi word.
- CHI_VALID  in  1  CHI carries a word this cycle. No backpressure to the sender.
- CHI_FIRST  in  1  qualifies CHI_VALID; marks the word as CHI1 of a new triple.
- CHI1, CHI2, CHI3  out  PARAMETERBITS each  reconstructed triple (registered).
- CHI_BEST  out  PARAMETERBITS  minimum of the triple (registered).
- SEL_BEST  out  2  index of CHI_BEST: 00, 01 or 10.
- OUT_VALID  out  1  output slot holds an unconsumed triple.
- OUT_READY  in  1  consumer accepts the slot when OUT_VALID && OUT_READY.
- FRAME_ERR  out  1  one-cycle pulse on a framing violation.
- OVERFLOW  out  1  one-cycle pulse when a completed triple is dropped.

Behaviour:
- Reset (async assert, sync-style release on CLOCK): state=IDLE.
  - Staging regs = 0.
  - CHI1/2/3 = 0, CHI_BEST = 0, SEL_BEST = 00.
  - OUT_VALID = 0, FRAME_ERR = 0, OVERFLOW = 0.
  - Reset mid-triple or with OUT_VALID=1 discards everything.
- Input FSM. States IDLE, GOT1, GOT2. Advances only on cycles with CHI_VALID=1; with CHI_VALID=0 it holds state and CHI_FIRST is ignored.
  - IDLE:
    - FIRST=1: stage S1<=CHI, go to GOT1.
    - FIRST=0: drop word, FRAME_ERR pulse, stay in IDLE.
  - GOT1:
    - FIRST=0: S2<=CHI, go to GOT2.
    - FIRST=1: FRAME_ERR pulse, S1<=CHI (restart), stay in GOT1.
  - GOT2:
    - FIRST=0: triple complete with (S1, S2, CHI), go to IDLE.
    - FIRST=1: FRAME_ERR pulse, S1<=CHI, go to GOT1.
- Best selection, evaluated in the completion cycle on (S1, S2, CHI):
  - Unsigned compare.
  - On ties the lowest index wins. For example, all three equal gives SEL_BEST=00; S2==CHI < S1 gives 01.
- Output slot:
  - The slot is free if OUT_VALID=0, or if OUT_VALID && OUT_READY in the same cycle (same-cycle consume and refill is allowed, giving back-to-back throughput).
  - Completion with the slot free: at the next edge, CHI1/2/3, CHI_BEST and SEL_BEST are loaded and OUT_VALID=1.
  - Completion with the slot full: the triple is dropped, OVERFLOW pulses 1 cycle, and the outputs and OUT_VALID are unchanged.
  - Consume with no completion: OUT_VALID<=0 and data regs hold their last value.
  - Outputs are stable while OUT_VALID && !OUT_READY.
- Latency:
  - Third word sampled at edge N → OUT_VALID=1 and data visible after edge N.
  - Minimum triple period is 3 cycles.
  - FRAME_ERR and OVERFLOW are registered and asserted the cycle after the offending word.

Decomposition:
- Shared package (chi_pkg):
  - PARAMETERBITS default.
  - SEL coding constants SEL_CHI1=2'b00, SEL_CHI2=2'b01, SEL_CHI3=2'b10.
  - FSM state encoding IDLE/GOT1/GOT2.
  - These are shared with the transmit-side chi mux.
- One sub-module: chi_min3. Combinational 3-input unsigned minimum with lowest-index tie-break; outputs value and 2-bit index. Reusable by other fitter stages.

Test Plan:
- Clean triple: words 100 (FIRST=1), 50, 75, OUT_READY=1 → CHI1/2/3=100/50/75, CHI_BEST=50, SEL_BEST=01, OUT_VALID high 1 cycle after the third word.
- Ties and max value: triples (7,7,7) → SEL_BEST=00; (16383,9,9) → CHI_BEST=9, SEL_BEST=01; (0,16383,0) → 00.
- Framing: 10(F=1), 20(F=1), 30, 40 → FRAME_ERR pulse once; output 20/30/40, best 20, SEL 00. A leading word with F=0 in IDLE → FRAME_ERR, no output.
- Backpressure/overflow: OUT_READY=0, two back-to-back triples → first held stable, OVERFLOW pulses on the second completion, outputs unchanged. Raise OUT_READY → OUT_VALID drops next cycle.
- Same-cycle refill: continuous triples with OUT_READY=1 at the completion cycle → OUT_VALID stays 1, new data loaded, no OVERFLOW.
- Reset mid-operation: assert RESET_N=0 in GOT2 with OUT_VALID=1 → all outputs 0 immediately (async); after release, a word with F=0 gives FRAME_ERR and a new clean triple decodes correctly.

Source files
------------

// File: rtl/chi_pkg.sv
// Shared chi-path definitions: default word width, SEL coding and receive FSM states.
// The SEL coding is also consumed by the transmit-side chi mux.
package chi_pkg;

    localparam int PARAMETERBITS_DEFAULT = 14;

    localparam logic [1:0] SEL_CHI1 = 2'b00;
    localparam logic [1:0] SEL_CHI2 = 2'b01;
    localparam logic [1:0] SEL_CHI3 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GOT1 = 2'b01,
        GOT2 = 2'b10
    } chi_state_e;

endpackage

// File: rtl/chi_min3.sv
// Three-input unsigned minimum with lowest-index tie-break; returns value and SEL index.
// Latency: combinational. Backpressure: none.
// Index coding follows SEL_CHI1/2/3, so 2'b11 is never produced.
module chi_min3
    import chi_pkg::*;
#(
    parameter int W = PARAMETERBITS_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] min_val,
    output logic [1:0]   min_idx
);

    // <= comparisons let the earlier operand win every tie
    always_comb begin
        min_val = c;
        min_idx = SEL_CHI3;
        if (a <= b && a <= c) begin
            min_val = a;
            min_idx = SEL_CHI1;
        end else if (b <= c) begin
            min_val = b;
            min_idx = SEL_CHI2;
        end
    end

endmodule

// File: rtl/chi_deser.sv
// Rebuilds chi triples from a one-word-per-cycle stream and selects the minimum.
// Latency: result valid the cycle after the third word; FRAME_ERR/OVERFLOW pulse one cycle after the word.
// Backpressure: none to the sender; a completed triple is dropped (OVERFLOW) while the output slot is held.
module chi_deser
    import chi_pkg::*;
#(
    parameter int PARAMETERBITS = PARAMETERBITS_DEFAULT
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic [PARAMETERBITS-1:0] CHI,
    input  logic                     CHI_VALID,
    input  logic                     CHI_FIRST,
    output logic [PARAMETERBITS-1:0] CHI1,
    output logic [PARAMETERBITS-1:0] CHI2,
    output logic [PARAMETERBITS-1:0] CHI3,
    output logic [PARAMETERBITS-1:0] CHI_BEST,
    output logic [1:0]               SEL_BEST,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     FRAME_ERR,
    output logic                     OVERFLOW
);

    chi_state_e               state_q, state_d;
    logic [PARAMETERBITS-1:0] s1_q, s1_d;
    logic [PARAMETERBITS-1:0] s2_q, s2_d;
    logic                     complete;
    logic                     ferr_d;
    logic                     slot_free;
    logic                     load;
    logic [PARAMETERBITS-1:0] best_val;
    logic [1:0]               best_idx;

    chi_min3 #(.W(PARAMETERBITS)) u_min3 (
        .a       (s1_q),
        .b       (s2_q),
        .c       (CHI),
        .min_val (best_val),
        .min_idx (best_idx)
    );

    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
        if (CHI_VALID) begin
            unique case (state_q)
                IDLE: begin
                    if (CHI_FIRST) begin
                        s1_d    = CHI;
                        state_d = GOT1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
                GOT1: begin
                    if (CHI_FIRST) begin
                        ferr_d  = 1'b1;
                        s1_d    = CHI;
                    end else begin
                        s2_d    = CHI;
                        state_d = GOT2;
                    end
                end
                GOT2: begin
                    if (CHI_FIRST) begin
                        ferr_d  = 1'b1;
                        s1_d    = CHI;
                        state_d = GOT1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A slot being consumed this cycle can be refilled in the same cycle
    assign slot_free = !OUT_VALID || OUT_READY;
    assign load      = complete && slot_free;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            CHI1      <= '0;
            CHI2      <= '0;
            CHI3      <= '0;
            CHI_BEST  <= '0;
            SEL_BEST  <= SEL_CHI1;
            OUT_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            FRAME_ERR <= ferr_d;
            OVERFLOW  <= complete && !slot_free;
            if (load) begin
                CHI1      <= s1_q;
                CHI2      <= s2_q;
                CHI3      <= CHI;
                CHI_BEST  <= best_val;
                SEL_BEST  <= best_idx;
                OUT_VALID <= 1'b1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule
